// File: rtl/vfu_sequencer_if.sv
// Command, vector-memory, vectorfu and status signals of the strip-mining sequencer.
// The master modport is the sequencer; the slave modport is decode/memory/vectorfu.
interface vfu_sequencer_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 10,
    parameter int unsigned LENW  = 8
);
    logic                  start_valid;
    logic                  start_ready;
    logic [2:0]            op;
    logic [AW-1:0]         src_a;
    logic [AW-1:0]         src_b;
    logic [AW-1:0]         dst;
    logic [LENW-1:0]       vlen;

    logic                  mem_rd_en;
    logic [AW-1:0]         mem_rd_addr;
    logic [LANES*DW-1:0]   mem_rd_data;
    logic                  mem_wr_en;
    logic [AW-1:0]         mem_wr_addr;
    logic [LANES*DW-1:0]   mem_wr_data;
    logic [LANES-1:0]      mem_wr_mask;

    logic [DW-1:0]         fu_a      [LANES];
    logic [DW-1:0]         fu_b      [LANES];
    logic [2:0]            fu_op;
    logic [DW-1:0]         fu_result [LANES];

    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start_valid, op, src_a, src_b, dst, vlen, mem_rd_data, fu_result,
        output start_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               mem_wr_mask, fu_a, fu_b, fu_op, busy, done, err
    );

    modport slave (
        output start_valid, op, src_a, src_b, dst, vlen, mem_rd_data, fu_result,
        input  start_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               mem_wr_mask, fu_a, fu_b, fu_op, busy, done, err
    );
endinterface

// File: rtl/vfu_sequencer.sv
// Strip-mining controller: walks a vector command in LANES-element chunks through the
// vector memory port, drives vectorfu and writes masked results back.
module vfu_sequencer #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 10,
    parameter int unsigned LENW  = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    vfu_sequencer_if.master bus
);
    localparam int unsigned IW = LENW + 1;

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StExec, StWr, StDone} state_e;

    state_e          r_state, w_state_next;
    logic [2:0]      r_op;
    logic [AW-1:0]   r_src_a, r_src_b, r_dst;
    logic [LENW-1:0] r_vlen;
    logic [IW-1:0]   r_idx;
    logic [DW-1:0]   r_a   [LANES];
    logic [DW-1:0]   r_b   [LANES];
    logic [DW-1:0]   r_res [LANES];

    logic            w_accept;
    logic            w_illegal;
    logic            w_more;
    logic [AW-1:0]   w_offs;

    assign w_accept  = (r_state == StIdle) && bus.start_valid;
    assign w_illegal = (r_op > 3'd2);
    assign w_more    = (32'(r_idx) + LANES) < 32'(r_vlen);
    assign w_offs    = AW'(r_idx);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_op    <= '0;
            r_src_a <= '0;
            r_src_b <= '0;
            r_dst   <= '0;
            r_vlen  <= '0;
            r_idx   <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_res[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= bus.op;
                r_src_a <= bus.src_a;
                r_src_b <= bus.src_b;
                r_dst   <= bus.dst;
                r_vlen  <= bus.vlen;
                r_idx   <= '0;
            end
            if (r_state == StRdB) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_a[i] <= bus.mem_rd_data[i*DW +: DW];
                end
            end
            if (r_state == StExec) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_b[i]   <= bus.mem_rd_data[i*DW +: DW];
                    r_res[i] <= bus.fu_result[i];
                end
            end
            if (r_state == StWr) begin
                r_idx <= r_idx + IW'(LANES);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.start_valid) begin
                    w_state_next = (bus.vlen == '0 || bus.op > 3'd2) ? StDone : StRdA;
                end
            end
            StRdA:   w_state_next = StRdB;
            StRdB:   w_state_next = StExec;
            StExec:  w_state_next = StWr;
            StWr:    w_state_next = w_more ? StRdA : StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // B data lands during EXEC; forward it so vectorfu sees this chunk's B operand.
    always_comb begin
        bus.fu_op = r_op;
        for (int unsigned i = 0; i < LANES; i++) begin
            bus.fu_a[i] = r_a[i];
            bus.fu_b[i] = (r_state == StExec) ? bus.mem_rd_data[i*DW +: DW] : r_b[i];
        end
    end

    // Strobes are suppressed in a reset cycle so an aborted command never touches memory.
    always_comb begin
        bus.start_ready = (r_state == StIdle);
        bus.busy        = (r_state != StIdle);
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        bus.mem_wr_mask = '0;
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        unique case (r_state)
            StRdA: begin
                bus.mem_rd_en   = !i_rst;
                bus.mem_rd_addr = r_src_a + w_offs;
            end
            StRdB: begin
                bus.mem_rd_en   = !i_rst;
                bus.mem_rd_addr = r_src_b + w_offs;
            end
            StWr: begin
                bus.mem_wr_en   = !i_rst;
                bus.mem_wr_addr = r_dst + w_offs;
                for (int unsigned i = 0; i < LANES; i++) begin
                    bus.mem_wr_data[i*DW +: DW] = r_res[i];
                    bus.mem_wr_mask[i]          = (32'(r_idx) + i) < 32'(r_vlen);
                end
            end
            StDone: begin
                bus.done = !i_rst;
                bus.err  = !i_rst && w_illegal;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_vfu_sequencer.sv
// Randomized and directed bench for vfu_sequencer against a cycle-schedule reference model.
module tb_vfu_sequencer;
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned LENW  = 8;
    localparam int          MEMSZ = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] mem [MEMSZ];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    vfu_sequencer_if #(.LANES(LANES), .DW(DW), .AW(AW), .LENW(LENW)) bus ();

    vfu_sequencer #(.LANES(LANES), .DW(DW), .AW(AW), .LENW(LENW)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] wa(input int x);
        return AW'(x);
    endfunction

    function automatic logic [DW-1:0] ref_op(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // vectorfu stand-in and synchronous vector memory
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bus.fu_result[i] = ref_op(bus.fu_op, bus.fu_a[i], bus.fu_b[i]);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.mem_rd_en) begin
            for (int i = 0; i < LANES; i++) begin
                bus.mem_rd_data[i*DW +: DW] <= mem[wa(int'(bus.mem_rd_addr) + i)];
            end
        end
        if (bus.mem_wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.mem_wr_mask[i]) mem[wa(int'(bus.mem_wr_addr) + i)] <= bus.mem_wr_data[i*DW +: DW];
            end
        end
    end

    // Reference model: command at acceptance period t0 with n chunks occupies periods
    // t0+1..t0+4n as (read A, read B, exec, write) per chunk, then done at t0+4n+1.
    bit         act = 0;
    int         t0 = 0, t_prev = 0;
    logic [2:0] m_op;
    int         m_a, m_b, m_d, m_len, m_n;
    int         d_lat = -1, ndone = 0, rd_seen = 0, wr_seen = 0, last_wr_addr = -1;
    logic       d_err = 1'b0;

    always @(negedge clk) begin
        logic e_ready, e_busy, e_rd, e_wr, e_done, e_err;
        logic [LANES-1:0] e_mask;
        int k, ph, c, e_rda, e_wra;
        e_ready = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
        e_mask = '0; e_rda = 0; e_wra = 0; k = 0; ph = 0; c = 0;
        if (bus.mem_rd_en) rd_seen++;
        if (bus.mem_wr_en) begin
            wr_seen++;
            last_wr_addr = int'(bus.mem_wr_addr);
        end
        if (rst) begin
            chk("rst_wr_en", bus.mem_wr_en, 0);
            chk("rst_done", bus.done, 0);
            act = 0;
        end else begin
            if (act) begin
                k = cyc - t0;
                e_ready = 1'b0;
                e_busy  = 1'b1;
                if (k == 4 * m_n + 1) begin
                    e_done = 1'b1;
                    e_err  = (m_op > 3'd2);
                end else begin
                    ph = (k - 1) % 4;
                    c  = (k - 1) / 4;
                    if (ph == 0) begin e_rd = 1'b1; e_rda = (m_a + 4 * c) % MEMSZ; end
                    if (ph == 1) begin e_rd = 1'b1; e_rda = (m_b + 4 * c) % MEMSZ; end
                    if (ph == 3) begin
                        e_wr  = 1'b1;
                        e_wra = (m_d + 4 * c) % MEMSZ;
                        for (int i = 0; i < LANES; i++) e_mask[i] = (4 * c + i) < m_len;
                    end
                end
            end
            chk("start_ready", bus.start_ready, e_ready);
            chk("busy", bus.busy, e_busy);
            chk("rd_en", bus.mem_rd_en, e_rd);
            chk("wr_en", bus.mem_wr_en, e_wr);
            chk("done", bus.done, e_done);
            chk("err", bus.err, e_err);
            if (e_rd) chk("rd_addr", bus.mem_rd_addr, e_rda);
            if (e_wr) begin
                chk("wr_addr", bus.mem_wr_addr, e_wra);
                chk("wr_mask", bus.mem_wr_mask, e_mask);
                for (int i = 0; i < LANES; i++) begin
                    if (e_mask[i]) begin
                        chk("wr_data", bus.mem_wr_data[i*DW +: DW],
                            ref_op(m_op, mem[wa(m_a + 4 * c + i)], mem[wa(m_b + 4 * c + i)]));
                    end
                end
            end
            if (bus.done) begin
                d_lat = cyc - t0;
                d_err = bus.err;
                ndone++;
            end
            if (e_done) act = 0;
            if (bus.start_valid && e_ready) begin
                t_prev = t0;
                t0     = cyc;
                m_op   = bus.op;
                m_a    = int'(bus.src_a);
                m_b    = int'(bus.src_b);
                m_d    = int'(bus.dst);
                m_len  = int'(bus.vlen);
                m_n    = (m_op > 3'd2) ? 0 : (m_len + LANES - 1) / LANES;
                act    = 1;
            end
        end
    end

    task automatic poke(input int addr, input logic [DW-1:0] val);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = wa(addr); pl_data = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input int a, input int b, input int d, input int len);
        int g;
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.op = op; bus.src_a = wa(a); bus.src_b = wa(b); bus.dst = wa(d); bus.vlen = LENW'(len);
        g = 0;
        forever begin
            @(negedge clk);
            if (bus.start_ready) break;
            g++;
            if (g > 3000) begin fail("accept_timeout"); break; end
        end
        @(posedge clk); #1;
        // Scramble the command fields to show they were latched.
        bus.start_valid = 1'b0;
        bus.op = 3'($urandom); bus.src_a = AW'($urandom); bus.src_b = AW'($urandom);
        bus.dst = AW'($urandom); bus.vlen = LENW'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin @(negedge clk); g++; end while (bus.busy && g < 3000);
        if (bus.busy) fail("idle_timeout");
    endtask

    initial begin
        int rop, rlen, n0, w0, r0;
        bus.start_valid = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
        bus.vlen = '0;
        pl_en = 1'b1;
        for (int i = 0; i < MEMSZ; i++) begin
            pl_addr = wa(i); pl_data = $urandom;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.start_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_fu_a0", bus.fu_a[0], 0);
        chk("reset_fu_b3", bus.fu_b[3], 0);
        chk("reset_fu_op", bus.fu_op, 0);

        // 1: add, one full chunk
        poke(100, 5); poke(101, 8); poke(102, 32'h12); poke(103, 32'h20);
        poke(200, 2); poke(201, 4); poke(202, 6);     poke(203, 32'h10);
        issue(3'd0, 100, 200, 300, 4);
        wait_idle();
        chk("t1_d0", mem[300], 7);
        chk("t1_d1", mem[301], 32'hC);
        chk("t1_d2", mem[302], 32'h18);
        chk("t1_d3", mem[303], 32'h30);
        chk("t1_lat", d_lat, 5);
        chk("t1_err", d_err, 0);

        // 2: mul with tail chunk
        for (int i = 0; i < 6; i++) begin poke(400 + i, i + 1); poke(500 + i, 3); end
        poke(606, 32'hDEADBEEF); poke(607, 32'hDEADBEEF);
        issue(3'd2, 400, 500, 600, 6);
        wait_idle();
        chk("t2_d0", mem[600], 3);
        chk("t2_d3", mem[603], 12);
        chk("t2_d4", mem[604], 15);
        chk("t2_d5", mem[605], 18);
        chk("t2_keep6", mem[606], 32'hDEADBEEF);
        chk("t2_keep7", mem[607], 32'hDEADBEEF);
        chk("t2_lat", d_lat, 9);

        // 3: sub wraps modulo 2^DW
        poke(10, 2); poke(11, 0); poke(12, 7); poke(13, 9);
        poke(20, 5); poke(21, 1); poke(22, 7); poke(23, 0);
        issue(3'd1, 10, 20, 30, 4);
        wait_idle();
        chk("t3_d0", mem[30], 32'hFFFFFFFD);
        chk("t3_d1", mem[31], 32'hFFFFFFFF);
        chk("t3_d2", mem[32], 0);
        chk("t3_d3", mem[33], 9);

        // 4: empty and illegal commands skip memory
        r0 = rd_seen; w0 = wr_seen;
        issue(3'd0, 1, 2, 3, 0);
        wait_idle();
        chk("t4_len0_lat", d_lat, 1);
        chk("t4_len0_err", d_err, 0);
        issue(3'd3, 1, 2, 3, 4);
        wait_idle();
        chk("t4_ill_lat", d_lat, 1);
        chk("t4_ill_err", d_err, 1);
        chk("t4_no_rd", rd_seen - r0, 0);
        chk("t4_no_wr", wr_seen - w0, 0);

        // 5: destination wraps past 2^AW; then a held request waits for the first to finish
        poke(700, 1);  poke(701, 2);  poke(702, 3);  poke(703, 4);
        poke(710, 10); poke(711, 20); poke(712, 30); poke(713, 40);
        issue(3'd0, 700, 710, 1022, 4);
        wait_idle();
        chk("t5_wr_addr", last_wr_addr, 1022);
        chk("t5_m1022", mem[1022], 11);
        chk("t5_m1023", mem[1023], 22);
        chk("t5_m0", mem[0], 33);
        chk("t5_m1", mem[1], 44);
        n0 = ndone;
        issue(3'd0, 40, 50, 60, 4);
        issue(3'd2, 70, 80, 90, 3);
        wait_idle();
        chk("t5_gap", t0 - t_prev, 6);
        chk("t5_ndone", ndone - n0, 2);

        // 6: reset during EXEC aborts the command
        w0 = wr_seen; n0 = ndone;
        issue(3'd0, 100, 200, 800, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready", bus.start_ready, 1);
        chk("t6_busy", bus.busy, 0);
        chk("t6_fu_a1", bus.fu_a[1], 0);
        chk("t6_fu_b2", bus.fu_b[2], 0);
        chk("t6_wr_data", bus.mem_wr_data, 0);
        chk("t6_rd_addr", bus.mem_rd_addr, 0);
        repeat (10) @(negedge clk);
        chk("t6_no_wr", wr_seen - w0, 0);
        chk("t6_no_done", ndone - n0, 0);

        // Random commands, sometimes back to back
        for (int j = 0; j < 40; j++) begin
            rop  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            rlen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 13));
            issue(3'(rop), int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(0, MEMSZ - 1)),
                  int'($urandom_range(0, MEMSZ - 1)), rlen);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
